// File: rtl/imem_loader.sv
// Byte-stream program loader: COUNT, 2N data bytes (high byte first), XOR CSUM; writes 16-bit words from address 0 one cycle after each LO byte.
// Holds cpu_reset until the checksum passes; rx_ready is low in RUN and during reset, and producers hold their byte until accepted.
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  input  logic          reload,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [15:0]   imem_wdata,
  output logic          cpu_reset,
  output logic          done,
  output logic          error,
  output logic [AW:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  state_t        state;
  logic [AW:0]   word_total;
  logic [AW:0]   word_idx;
  logic [AW-1:0] addr;
  logic [7:0]    acc;
  logic [7:0]    hi_byte;
  logic          xfer;
  logic          last_word;

  assign rx_ready  = !reset && (state != S_RUN);
  assign xfer      = rx_valid && rx_ready;
  assign last_word = (word_idx == word_total - (AW+1)'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      word_total   <= '0;
      word_idx     <= '0;
      addr         <= '0;
      acc          <= '0;
      hi_byte      <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      // words_loaded trails the write strobe by one cycle
      if (imem_we) begin
        words_loaded <= words_loaded + (AW+1)'(1);
      end
      case (state)
        S_IDLE, S_ERR: begin
          if (xfer) begin
            // A COUNT of zero stands for a full memory image
            word_total   <= (rx_data == 8'd0) ? (AW+1)'(DEPTH) : (AW+1)'(rx_data);
            word_idx     <= '0;
            addr         <= '0;
            acc          <= '0;
            words_loaded <= '0;
            error        <= 1'b0;
            state        <= S_HI;
          end
        end
        S_HI: begin
          if (xfer) begin
            hi_byte <= rx_data;
            acc     <= acc ^ rx_data;
            state   <= S_LO;
          end
        end
        S_LO: begin
          if (xfer) begin
            imem_we    <= 1'b1;
            imem_addr  <= addr;
            imem_wdata <= {hi_byte, rx_data};
            addr       <= addr + AW'(1);
            acc        <= acc ^ rx_data;
            word_idx   <= word_idx + (AW+1)'(1);
            state      <= last_word ? S_CSUM : S_HI;
          end
        end
        S_CSUM: begin
          if (xfer) begin
            if (rx_data == acc) begin
              state     <= S_RUN;
              cpu_reset <= 1'b0;
              done      <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (reload) begin
            state     <= S_IDLE;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: expected memory writes are queued with their due cycle when the LO byte is accepted
// and matched by a monitor on every write strobe; status outputs are checked inline by each scenario task.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready;
  logic        reload = 1'b0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  imem_loader #(.DEPTH(256), .AW(8)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         sb[$];
  wr_t         mon_e;
  int          cyc = 0;
  int          xfer_cnt = 0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [15:0] img [256];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (rx_valid && rx_ready) xfer_cnt <= xfer_cnt + 1;
  end

  // Scoreboard monitor: every strobe must match the oldest queued write in cycle, address and data
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      chk_cnt++;
      $display("FAIL missed_write: no strobe in cycle %0d, required addr=%h data=%h", mon_e.cyc, mon_e.addr, mon_e.data);
    end
    if (imem_we === 1'b1) begin
      chk_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_write: cycle %0d addr=%h data=%h, required no write", cyc, imem_addr, imem_wdata);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != cyc || imem_addr !== mon_e.addr || imem_wdata !== mon_e.data)
          $display("FAIL write: got cycle %0d addr=%h data=%h, required cycle %0d addr=%h data=%h",
                   cyc, imem_addr, imem_wdata, mon_e.cyc, mon_e.addr, mon_e.data);
        else
          pass_cnt++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit is_lo, input logic [7:0] a, input logic [15:0] w);
    int start;
    bit got;
    start    = xfer_cnt;
    got      = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clock);
      #1;
      if (xfer_cnt != start) got = 1'b1;
    end
    if (!got) begin
      chk_cnt++;
      $display("FAIL send_timeout: byte %h not accepted within 50 cycles, required acceptance", b);
      rx_valid = 1'b0;
    end else if (is_lo) begin
      sb.push_back('{cyc, a, w});
    end
  endtask

  task automatic gap();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_image(input int n, input bit bad, input bit gaps);
    logic [7:0] cs;
    cs = 8'd0;
    if (gaps) gap();
    send_byte(8'(n), 1'b0, 8'd0, 16'd0);
    for (int k = 0; k < n; k++) begin
      cs = cs ^ img[k][15:8] ^ img[k][7:0];
      if (gaps) gap();
      send_byte(img[k][15:8], 1'b0, 8'd0, 16'd0);
      if (gaps) gap();
      send_byte(img[k][7:0], 1'b1, 8'(k), img[k]);
    end
    if (bad) cs = cs ^ 8'h01;
    if (gaps) gap();
    send_byte(cs, 1'b0, 8'd0, 16'd0);
    rx_valid = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clock);
    #1;
    reload = 1'b0;
    @(negedge clock);
    chk_cnt++;
    if ({cpu_reset, done, rx_ready} !== 3'b101)
      $display("FAIL reload_status: {cpu_reset,done,rx_ready}=%b, required 101", {cpu_reset, done, rx_ready});
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_cnt++;
    if ({rx_ready, cpu_reset, imem_we, done, error} !== 5'b01000)
      $display("FAIL reset_flags: {rx_ready,cpu_reset,imem_we,done,error}=%b, required 01000",
               {rx_ready, cpu_reset, imem_we, done, error});
    else
      pass_cnt++;
    chk_cnt++;
    if (imem_addr !== 8'd0 || imem_wdata !== 16'd0 || words_loaded !== 9'd0)
      $display("FAIL reset_values: addr=%h wdata=%h words=%0d, required 0/0/0", imem_addr, imem_wdata, words_loaded);
    else
      pass_cnt++;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk_cnt++;
    if ({rx_ready, cpu_reset} !== 2'b11)
      $display("FAIL post_reset: {rx_ready,cpu_reset}=%b, required 11", {rx_ready, cpu_reset});
    else
      pass_cnt++;
  endtask

  task automatic test_basic();
    img[0] = 16'h1234;
    img[1] = 16'hABCD;
    send_image(2, 1'b0, 1'b0);
    @(negedge clock);
    chk_cnt++;
    if ({cpu_reset, done, error, rx_ready} !== 4'b0100)
      $display("FAIL basic_release: {cpu_reset,done,error,rx_ready}=%b, required 0100", {cpu_reset, done, error, rx_ready});
    else
      pass_cnt++;
    chk_cnt++;
    if (words_loaded !== 9'd2)
      $display("FAIL basic_words: words_loaded=%0d, required 2", words_loaded);
    else
      pass_cnt++;
  endtask

  task automatic test_checksum_error();
    do_reload();
    send_image(2, 1'b1, 1'b0);
    @(negedge clock);
    chk_cnt++;
    if ({cpu_reset, done, error, rx_ready} !== 4'b1011)
      $display("FAIL csum_error: {cpu_reset,done,error,rx_ready}=%b, required 1011", {cpu_reset, done, error, rx_ready});
    else
      pass_cnt++;
    send_byte(8'h01, 1'b0, 8'd0, 16'd0);
    rx_valid = 1'b0;
    @(negedge clock);
    chk_cnt++;
    if ({cpu_reset, done, error} !== 3'b100)
      $display("FAIL error_clear: {cpu_reset,done,error}=%b, required 100", {cpu_reset, done, error});
    else
      pass_cnt++;
    send_byte(8'h00, 1'b0, 8'd0, 16'd0);
    send_byte(8'h07, 1'b1, 8'd0, 16'h0007);
    send_byte(8'h07, 1'b0, 8'd0, 16'd0);
    rx_valid = 1'b0;
    @(negedge clock);
    chk_cnt++;
    if ({cpu_reset, done, error} !== 3'b010 || words_loaded !== 9'd1)
      $display("FAIL recover: {cpu_reset,done,error}=%b words=%0d, required 010 and 1", {cpu_reset, done, error}, words_loaded);
    else
      pass_cnt++;
  endtask

  task automatic test_gaps();
    do_reload();
    img[0] = 16'h5A01;
    img[1] = 16'hC3F0;
    img[2] = 16'h0F77;
    send_image(3, 1'b0, 1'b1);
    @(negedge clock);
    chk_cnt++;
    if ({cpu_reset, done, error} !== 3'b010 || words_loaded !== 9'd3)
      $display("FAIL gaps_done: {cpu_reset,done,error}=%b words=%0d, required 010 and 3", {cpu_reset, done, error}, words_loaded);
    else
      pass_cnt++;
  endtask

  task automatic test_full_image();
    do_reload();
    for (int k = 0; k < 256; k++) img[k] = {8'(2 * k), 8'(2 * k + 1)};
    send_image(256, 1'b0, 1'b0);
    @(negedge clock);
    chk_cnt++;
    if ({cpu_reset, done, error} !== 3'b010 || words_loaded !== 9'd256)
      $display("FAIL full_done: {cpu_reset,done,error}=%b words=%0d, required 010 and 256", {cpu_reset, done, error}, words_loaded);
    else
      pass_cnt++;
  endtask

  task automatic test_run_ignore();
    logic [8:0] wl;
    wl       = words_loaded;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (3) begin
      @(negedge clock);
      chk_cnt++;
      if (rx_ready !== 1'b0 || done !== 1'b1 || cpu_reset !== 1'b0 || words_loaded !== wl)
        $display("FAIL run_ignore: rx_ready=%b done=%b cpu_reset=%b words=%0d, required 0/1/0/%0d",
                 rx_ready, done, cpu_reset, words_loaded, wl);
      else
        pass_cnt++;
    end
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
    do_reload();
    img[0] = 16'h1234;
    img[1] = 16'h5678;
    send_image(2, 1'b0, 1'b0);
    @(negedge clock);
    chk_cnt++;
    if ({cpu_reset, done} !== 2'b01 || words_loaded !== 9'd2)
      $display("FAIL reload_image: {cpu_reset,done}=%b words=%0d, required 01 and 2", {cpu_reset, done}, words_loaded);
    else
      pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reload();
    img[0] = 16'hDEAD;
    img[1] = 16'hBEEF;
    img[2] = 16'hCAFE;
    img[3] = 16'hF00D;
    send_byte(8'h04, 1'b0, 8'd0, 16'd0);
    send_byte(img[0][15:8], 1'b0, 8'd0, 16'd0);
    send_byte(img[0][7:0], 1'b1, 8'd0, img[0]);
    send_byte(img[1][15:8], 1'b0, 8'd0, 16'd0);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clock);
    chk_cnt++;
    if (rx_ready !== 1'b0)
      $display("FAIL ready_in_reset: rx_ready=%b, required 0", rx_ready);
    else
      pass_cnt++;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk_cnt++;
    if ({cpu_reset, done, error, imem_we, rx_ready} !== 5'b10001 || words_loaded !== 9'd0)
      $display("FAIL mid_reset: {cpu_reset,done,error,imem_we,rx_ready}=%b words=%0d, required 10001 and 0",
               {cpu_reset, done, error, imem_we, rx_ready}, words_loaded);
    else
      pass_cnt++;
    send_image(4, 1'b0, 1'b0);
    @(negedge clock);
    chk_cnt++;
    if ({cpu_reset, done, error} !== 3'b010 || words_loaded !== 9'd4)
      $display("FAIL mid_reset_reload: {cpu_reset,done,error}=%b words=%0d, required 010 and 4", {cpu_reset, done, error}, words_loaded);
    else
      pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_checksum_error();
    test_gaps();
    test_full_image();
    test_run_ignore();
    test_reset_mid();
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk_cnt++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", sb.size());
    else
      pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
